// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous SRAM. The default build is round-robin.
// Define SRAM_ARB_FIXED_PRIO_EN to select fixed priority, where port 0 always wins contention.
module sram_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Rw0,
    input  logic              Rw1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Rvalid0,
    output logic              Rvalid1,
    output logic [DATA_W-1:0] Rdata0,
    output logic [DATA_W-1:0] Rdata1,
    output logic              Mem_En,
    output logic              Mem_Rw,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Din,
    input  logic [DATA_W-1:0] Mem_Dout,
    output logic              Busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StRead} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                grant_sel;  // 1 selects port 1

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign grant_sel = ~Req0;
`else
    logic ptr_q, ptr_d;  // last granted port

    assign grant_sel = (Req0 && Req1) ? ~ptr_q : Req1;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_en_d   = 1'b0;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = busy_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    state_d  = StIssue;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    owner_d  = grant_sel;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    ptr_d    = grant_sel;
`endif
                    if (grant_sel) begin
                        mem_rw_d   = Rw1;
                        mem_addr_d = Addr1;
                        mem_din_d  = Wdata1;
                        ack1_d     = 1'b1;
                    end else begin
                        mem_rw_d   = Rw0;
                        mem_addr_d = Addr0;
                        mem_din_d  = Wdata0;
                        ack0_d     = 1'b1;
                    end
                end
            end
            StIssue: begin
                // SRAM samples the access on this edge; reads need one more cycle for Dout.
                if (mem_rw_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (owner_q) begin
                    rdata1_d  = Mem_Dout;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = Mem_Dout;
                    rvalid0_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign Rvalid0  = rvalid0_q;
    assign Rvalid1  = rvalid1_q;
    assign Rdata0   = rdata0_q;
    assign Rdata1   = rdata1_q;
    assign Mem_En   = mem_en_q;
    assign Mem_Rw   = mem_rw_q;
    assign Mem_Addr = mem_addr_q;
    assign Mem_Din  = mem_din_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a transaction-level model predicts every output each cycle.
module tb_sram_arbiter;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_rw;
    logic [6:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        busy;

    sram_arbiter #(.DATA_W(32), .ADDR_W(7)) dut (
        .Clk(clk), .Rst(rst),
        .Req0(req0), .Req1(req1), .Rw0(rw0), .Rw1(rw1),
        .Addr0(addr0), .Addr1(addr1), .Wdata0(wdata0), .Wdata1(wdata1),
        .Ack0(ack0), .Ack1(ack1), .Rvalid0(rvalid0), .Rvalid1(rvalid1),
        .Rdata0(rdata0), .Rdata1(rdata1),
        .Mem_En(mem_en), .Mem_Rw(mem_rw), .Mem_Addr(mem_addr), .Mem_Din(mem_din),
        .Mem_Dout(mem_dout), .Busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM environment: registered read data, no reset.
    logic [31:0] sram [128];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycles-remaining counter plus a predicted memory image.
    logic [31:0] ref_mem [128];
    int          cnt;
    bit          rd_flag;
    int          pend_port;
    logic [31:0] pend_data;
    int          last;
    logic        e_ack [2];
    logic        e_rv [2];
    logic [31:0] e_rdata [2];
    logic        e_en, e_rw;
    logic [6:0]  e_addr;
    logic [31:0] e_din;

    req_t q0 [$];
    req_t q1 [$];

    task automatic model_reset();
        cnt = 0; rd_flag = 0; last = 1;
        for (int p = 0; p < 2; p++) begin
            e_ack[p] = 0; e_rv[p] = 0; e_rdata[p] = '0;
        end
        e_en = 0; e_rw = 0; e_addr = '0; e_din = '0;
    endtask

    task automatic model_step();
        int          w;
        logic        rw;
        logic [6:0]  a;
        logic [31:0] d;
        e_ack[0] = 0; e_ack[1] = 0; e_rv[0] = 0; e_rv[1] = 0; e_en = 0;
        if (rst) begin
            model_reset();
        end else if (cnt == 0) begin
            if (req0 || req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                w = req0 ? 0 : 1;
`else
                w = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
`endif
                last = w;
                rw = w ? rw1 : rw0;
                a  = w ? addr1 : addr0;
                d  = w ? wdata1 : wdata0;
                e_ack[w] = 1; e_en = 1; e_rw = rw; e_addr = a; e_din = d;
                if (rw) begin
                    ref_mem[a] = d;
                    cnt = 1;
                end else begin
                    pend_port = w;
                    pend_data = ref_mem[a];
                    rd_flag = 1;
                    cnt = 2;
                end
            end
        end else begin
            cnt--;
            if (cnt == 0 && rd_flag) begin
                rd_flag = 0;
                e_rv[pend_port] = 1;
                e_rdata[pend_port] = pend_data;
            end
        end
    endtask

    task automatic compare();
        check_eq("ack0", ack0, e_ack[0]);
        check_eq("ack1", ack1, e_ack[1]);
        check_eq("rvalid0", rvalid0, e_rv[0]);
        check_eq("rvalid1", rvalid1, e_rv[1]);
        check_eq("rdata0", rdata0, e_rdata[0]);
        check_eq("rdata1", rdata1, e_rdata[1]);
        check_eq("mem_en", mem_en, e_en);
        check_eq("mem_rw", mem_rw, e_rw);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_din", mem_din, e_din);
        check_eq("busy", busy, cnt != 0);
    endtask

    // Requesters pop on Ack and present their next queued request immediately.
    task automatic drive_requesters();
        if (e_ack[0] && q0.size() > 0) void'(q0.pop_front());
        if (e_ack[1] && q1.size() > 0) void'(q1.pop_front());
        req0 = q0.size() > 0;
        req1 = q1.size() > 0;
        if (req0) begin rw0 = q0[0].rw; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (req1) begin rw1 = q1[0].rw; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        drive_requesters();
    endtask

    function automatic req_t mk(input logic rw, input logic [6:0] a, input logic [31:0] d);
        req_t r;
        r.rw = rw; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic req_t rand_req();
        logic [6:0] a;
        a = ($urandom_range(0, 8) == 8) ? 7'd127 : 7'($urandom_range(0, 7));
        return mk(1'($urandom_range(0, 1)), a, $urandom);
    endfunction

    task automatic drain();
        bit idle;
        idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            cycle();
            idle = (q0.size() == 0) && (q1.size() == 0) && (cnt == 0);
        end
        check_eq("drain", idle, 1);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
            if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
            drive_requesters();
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 128; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        mem_dout = '0;
        rst = 1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_reset();
        #2;
        compare();

        // Simultaneous write/read of addr 127 straight out of reset: port 0 reads old data.
        q1.push_back(mk(1, 7'd127, 32'hCAFE_0001));
        q0.push_back(mk(0, 7'd127, 32'h0));
        drive_requesters();
        cycle();
        cycle();
        rst = 0;
        drain();
        check_eq("rd127_old", rdata0, 32'h0);

        q0.push_back(mk(1, 7'd5, 32'hDEAD_BEEF));
        q0.push_back(mk(0, 7'd5, 32'h0));
        drain();
        check_eq("deadbeef", rdata0, 32'hDEAD_BEEF);
        check_eq("rdata1_untouched", rdata1, 32'h0);

        q0.push_back(mk(1, 7'd1, 32'h11));
        q1.push_back(mk(1, 7'd2, 32'h22));
        drain();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 7'd1, 32'h0));
            q1.push_back(mk(0, 7'd2, 32'h0));
        end
        drain();
        check_eq("rd_addr1", rdata0, 32'h11);
        check_eq("rd_addr2", rdata1, 32'h22);

        for (int i = 0; i < 4; i++) q1.push_back(mk(1, 7'(i), 32'h100 + 32'(i)));
        drain();

        random_phase(1500);

        // Assert reset while a read sits in its data-capture cycle.
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (q0.size() == 0) q0.push_back(mk(0, 7'd5, 32'h0));
            cycle();
            found = (cnt == 1) && rd_flag;
        end
        check_eq("found_read", found, 1);
        rst = 1;
        #1;
        model_reset();
        compare();
        if (q0.size() == 0) q0.push_back(mk(0, 7'd1, 32'h0));
        if (q1.size() == 0) q1.push_back(mk(0, 7'd2, 32'h0));
        drive_requesters();
        cycle();
        rst = 0;
        cycle();
        check_eq("post_rst_grant0", ack0, 1);

        random_phase(1500);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
